// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide USB transmit port between N_REQ
// sources and frames each granted packet as PID, payload, CRC16 low, CRC16 high.
module usb_tx_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] req_pid,
    input  logic [N_REQ-1:0]   req_zlp,
    input  logic [8*N_REQ-1:0] src_data,
    input  logic [N_REQ-1:0]   src_valid,
    input  logic [N_REQ-1:0]   src_last,
    output logic [N_REQ-1:0]   src_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               tx_last,
    input  logic               tx_ready,
    output logic               busy,
    output logic               pkt_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PID  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CRC1 = 3'd3;
    localparam logic [2:0] ST_CRC2 = 3'd4;

    logic [2:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [3:0]       pid;
    logic             zlp;
    logic [15:0]      crc;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;
    logic [N_REQ-1:0] win_onehot;
    logic [3:0]       win_pid;
    logic             win_zlp;
    logic [7:0]       sel_data;

    // CRC16 (x^16+x^15+x^2+1), shifted LSB first in reflected form
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int b = 0; b < 8; b++) begin
            if (c[0] ^ data[b]) c = (c >> 1) ^ 16'hA001;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Search starts just above the last winner, so a persistent requester drops to lowest priority
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        win_pid    = '0;
        win_zlp    = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = PTR_W'((int'(ptr) + off) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = win_found;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_pid = req_pid[4*i +: 4];
                win_zlp = req_zlp[i];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ptr == PTR_W'(i)) sel_data = src_data[8*i +: 8];
        end
    end

    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        src_ready = '0;
        case (state)
            ST_PID: begin
                tx_data  = {~pid, pid};
                tx_valid = 1'b1;
            end
            ST_DATA: begin
                tx_data        = sel_data;
                tx_valid       = src_valid[ptr];
                src_ready[ptr] = tx_ready;
            end
            ST_CRC1: begin
                tx_data  = ~crc[7:0];
                tx_valid = 1'b1;
            end
            ST_CRC2: begin
                tx_data  = ~crc[15:8];
                tx_valid = 1'b1;
                tx_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            ptr      <= PTR_W'(N_REQ - 1);
            crc      <= 16'hFFFF;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        grant <= win_onehot;
                        ptr   <= win_idx;
                        crc   <= 16'hFFFF;
                        state <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (tx_ready) state <= zlp ? ST_CRC1 : ST_DATA;
                end
                ST_DATA: begin
                    if (tx_valid && tx_ready) begin
                        crc <= crc16_byte(crc, tx_data);
                        if (src_last[ptr]) state <= ST_CRC1;
                    end
                end
                ST_CRC1: begin
                    if (tx_ready) state <= ST_CRC2;
                end
                ST_CRC2: begin
                    if (tx_ready) begin
                        state    <= ST_IDLE;
                        grant    <= '0;
                        pkt_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Packet attributes are captured with the grant and need no reset
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && win_found) begin
            pid <= win_pid;
            zlp <= win_zlp;
        end
    end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: expected byte streams and grant order are
// queued when a packet is set up and compared as the DUT hands bytes over.
module tb_usb_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [4*N-1:0] req_pid = '0;
    logic [N-1:0]   req_zlp = '0;
    logic [8*N-1:0] src_data = '0;
    logic [N-1:0]   src_valid = '0;
    logic [N-1:0]   src_last = '0;
    logic [N-1:0]   src_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_last;
    logic           tx_ready = 1'b0;
    logic           busy;
    logic           pkt_done;

    usb_tx_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .req_pid(req_pid), .req_zlp(req_zlp),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
        .src_ready(src_ready), .grant(grant), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(tx_ready), .busy(busy), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [8:0]   sb[$];
    logic [N-1:0] gq[$];
    logic [7:0]   srcq[N][$];
    int           pkts_left[N];
    bit           bp = 0, bubbles = 0, exp_done = 0, prev_stall = 0;
    bit           zlp_watch = 0, saw_ready = 0;
    logic [7:0]   prev_data = '0;
    logic [N-1:0] prev_grant = '0;
    int           done_src = 0;
    int           data_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    // Payload byte k = base + k*inc; queues source bytes, tx bytes and the grant
    task automatic load_pkt(input int src, input logic [3:0] pid, input bit zlp,
                            input int n, input logic [7:0] base, input logic [7:0] inc);
        logic [15:0]  c;
        logic [7:0]   b;
        logic [N-1:0] g;
        req_pid[4*src +: 4] = pid;
        req_zlp[src] = zlp;
        sb.push_back({1'b0, ~pid, pid});
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k) * inc;
            srcq[src].push_back(b);
            sb.push_back({1'b0, b});
            c = crc_model(c, b);
        end
        sb.push_back({1'b0, ~c[7:0]});
        sb.push_back({1'b1, ~c[15:8]});
        g = '0;
        g[src] = 1'b1;
        gq.push_back(g);
        pkts_left[src]++;
    endtask

    task automatic step();
        logic [8:0]   e;
        logic [N-1:0] eg;
        @(negedge clk);
        tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && !(bubbles && $urandom_range(0, 2) == 0)) begin
                src_valid[i]        = 1'b1;
                src_data[8*i +: 8]  = srcq[i][0];
                src_last[i]         = (srcq[i].size() == 1);
            end else begin
                src_valid[i]        = 1'b0;
                src_data[8*i +: 8]  = 8'h00;
                src_last[i]         = 1'b0;
            end
        end
        #1;
        chk("pkt_done", pkt_done, exp_done);
        if (pkt_done && exp_done) begin
            pkts_left[done_src]--;
            if (pkts_left[done_src] <= 0) req[done_src] = 1'b0;
        end
        chk("grant_onehot", $onehot0(grant), 1);
        chk("src_ready_mask", src_ready & ~grant, 0);
        if (grant != 0 && prev_grant == 0) begin
            eg = (gq.size() > 0) ? gq.pop_front() : 'x;
            chk("grant_order", grant, eg);
        end else if (grant != 0) begin
            chk("grant_held", grant, prev_grant);
        end
        if (prev_stall && tx_valid) chk("tx_stable", tx_data, prev_data);
        if (zlp_watch && src_ready != 0) saw_ready = 1;
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && src_ready[i]) begin
                srcq[i].delete(0);
                data_cnt++;
            end
        end
        exp_done = 0;
        if (tx_valid && tx_ready) begin
            chk("tx_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("tx_byte", {tx_last, tx_data}, e);
            end
            if (tx_last) begin
                exp_done = 1;
                for (int i = 0; i < N; i++) if (grant[i]) done_src = i;
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_grant = grant;
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while (!(sb.size() == 0 && req == 0 && !busy && !exp_done) && n < max) begin
            step();
            n++;
        end
        chk("drain_in_time", n < max, 1);
    endtask

    task automatic run_until_data(input int target, input int max);
        int n;
        n = 0;
        data_cnt = 0;
        while (data_cnt < target && n < max) begin
            step();
            n++;
        end
        chk("data_in_time", n < max, 1);
    endtask

    // One-cycle synchronous reset, then check the idle outputs
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        tx_ready = 1'b0;
        src_valid = '0;
        src_last = '0;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            pkts_left[i] = 0;
        end
        sb.delete();
        gq.delete();
        @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_done", pkt_done, 0);
        reset = 1'b0;
        exp_done = 0;
        prev_stall = 0;
        prev_grant = grant;
    endtask

    initial begin
        for (int i = 0; i < N; i++) pkts_left[i] = 0;
        do_reset();

        load_pkt(0, 4'h3, 0, 4, 8'h00, 8'h01);
        req[0] = 1'b1;
        run_idle(200);

        zlp_watch = 1;
        saw_ready = 0;
        load_pkt(2, 4'hB, 1, 0, 8'h00, 8'h00);
        req[2] = 1'b1;
        run_idle(200);
        chk("zlp_src_ready", saw_ready, 0);
        zlp_watch = 0;

        do_reset();
        load_pkt(0, 4'h3, 1, 0, 8'h00, 8'h00);
        load_pkt(1, 4'hB, 1, 0, 8'h00, 8'h00);
        load_pkt(2, 4'h1, 1, 0, 8'h00, 8'h00);
        load_pkt(3, 4'h9, 1, 0, 8'h00, 8'h00);
        load_pkt(0, 4'h3, 1, 0, 8'h00, 8'h00);
        req = 4'b1111;
        run_idle(400);

        bp = 1;
        bubbles = 1;
        load_pkt(0, 4'h3, 0, 4, 8'h00, 8'h01);
        req[0] = 1'b1;
        run_idle(1000);
        bp = 0;
        bubbles = 0;

        load_pkt(0, 4'h5, 0, 4, 8'h10, 8'h10);
        req[0] = 1'b1;
        run_until_data(2, 200);
        do_reset();
        load_pkt(0, 4'h3, 0, 4, 8'h00, 8'h01);
        req[0] = 1'b1;
        run_idle(200);

        load_pkt(1, 4'h1, 0, 5, 8'hA0, 8'h11);
        load_pkt(2, 4'h9, 0, 2, 8'h5A, 8'h01);
        req[1] = 1'b1;
        req[2] = 1'b1;
        run_until_data(1, 200);
        req[1] = 1'b0;
        run_idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
